// File: rtl/mem_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_if
// Groups the three buses around the memory arbiter:
//   - fetch port  (i_*): request, address, flush in; read data, done out
//   - data port   (d_*): request, we, byte enables, address, wdata in;
//                        read data, done out
//   - stalls      (f_stall_o, m_stall_o) toward hazard control
//   - memory bus  (mem_*): request/we/be/addr/wdata out; gnt, rvalid, rdata in
// Handshake: a port raises *_req_i and holds its fields stable until it sees
// *_done_o. The memory accepts a request on a cycle where mem_req_o and
// mem_gnt_i are both high, and answers later with a one-cycle mem_rvalid_i.
// Modports:
//   slave  - the arbiter (consumes *_i, drives *_o)
//   master - the environment (core pipeline plus memory)
// -----------------------------------------------------------------------------
interface mem_bus_arbiter_if #(
   parameter int XLEN = 32,
   parameter int AW   = 32
);
   logic              i_req_i;
   logic [AW-1:0]     i_addr_i;
   logic              i_flush_i;
   logic [XLEN-1:0]   i_rdata_o;
   logic              i_done_o;

   logic              d_req_i;
   logic              d_we_i;
   logic [XLEN/8-1:0] d_be_i;
   logic [AW-1:0]     d_addr_i;
   logic [XLEN-1:0]   d_wdata_i;
   logic [XLEN-1:0]   d_rdata_o;
   logic              d_done_o;

   logic              f_stall_o;
   logic              m_stall_o;

   logic              mem_req_o;
   logic              mem_we_o;
   logic [XLEN/8-1:0] mem_be_o;
   logic [AW-1:0]     mem_addr_o;
   logic [XLEN-1:0]   mem_wdata_o;
   logic              mem_gnt_i;
   logic              mem_rvalid_i;
   logic [XLEN-1:0]   mem_rdata_i;

   modport slave (
      input  i_req_i, i_addr_i, i_flush_i,
      output i_rdata_o, i_done_o,
      input  d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
      output d_rdata_o, d_done_o,
      output f_stall_o, m_stall_o,
      output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
      input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
   );

   modport master (
      output i_req_i, i_addr_i, i_flush_i,
      input  i_rdata_o, i_done_o,
      output d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
      input  d_rdata_o, d_done_o,
      input  f_stall_o, m_stall_o,
      input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
      output mem_gnt_i, mem_rvalid_i, mem_rdata_i
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
// Shares one single-port memory bus between the fetch port (I) and the data
// port (D). One transaction is outstanding at a time: IDLE arbitrates, X_REQ
// holds the registered request until mem_gnt_i, X_WAIT waits for
// mem_rvalid_i and returns the data with a one-cycle done pulse.
// A fetch flushed while issued still completes its bus handshake, but its
// response is dropped (kill flag).
// Ports:
//   clk_i        clock, rising edge
//   rst          asynchronous active-low reset
//   bus          mem_bus_arbiter_if.slave (fetch, data, stall and memory buses)
//   o_dbg_state  current FSM state (state_t encoding)
// Optional build macro:
//   MEM_ARB_RR_EN  round-robin between I and D when both are eligible;
//                  undefined -> fixed D-over-I priority.
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
   parameter int XLEN = 32,
   parameter int AW   = 32
) (
   input  logic                  clk_i,
   input  logic                  rst,
   mem_bus_arbiter_if.slave      bus,
   output logic [2:0]            o_dbg_state
);
   localparam int BEW = XLEN / 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_I_REQ  = 3'd1,
      ST_I_WAIT = 3'd2,
      ST_D_REQ  = 3'd3,
      ST_D_WAIT = 3'd4
   } state_t;

   state_t            r_state, w_state_nxt;
   logic              r_kill, w_kill_nxt;
   logic              r_mem_req, w_mem_req_nxt;
   logic              r_mem_we, w_mem_we_nxt;
   logic [BEW-1:0]    r_mem_be, w_mem_be_nxt;
   logic [AW-1:0]     r_mem_addr, w_mem_addr_nxt;
   logic [XLEN-1:0]   r_mem_wdata, w_mem_wdata_nxt;
   logic [XLEN-1:0]   r_i_rdata, w_i_rdata_nxt;
   logic [XLEN-1:0]   r_d_rdata, w_d_rdata_nxt;
   logic              r_i_done, w_i_done_nxt;
   logic              r_d_done, w_d_done_nxt;

   logic              w_i_elig;
   logic              w_d_elig;
   logic              w_pick_d;

   // A port whose done pulse is high this cycle is still holding its request;
   // the done qualifier keeps that request from being issued a second time.
   assign w_i_elig = bus.i_req_i & ~r_i_done & ~bus.i_flush_i;
   assign w_d_elig = bus.d_req_i & ~r_d_done;

`ifdef MEM_ARB_RR_EN
   // 1 = D was granted last, 0 = I was granted last.
   logic r_last_grant_d;

   assign w_pick_d = w_d_elig & (~w_i_elig | ~r_last_grant_d);

   always_ff @(posedge clk_i or negedge rst) begin
      if (!rst) begin
         r_last_grant_d <= 1'b0;
      end else if (r_state == ST_IDLE && (w_d_elig || w_i_elig)) begin
         r_last_grant_d <= w_pick_d;
      end
   end
`else
   assign w_pick_d = w_d_elig;
`endif

   // State register
   always_ff @(posedge clk_i or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Registered bus/port outputs and the kill flag
   always_ff @(posedge clk_i or negedge rst) begin
      if (!rst) begin
         r_kill      <= 1'b0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_be    <= '0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_i_rdata   <= '0;
         r_d_rdata   <= '0;
         r_i_done    <= 1'b0;
         r_d_done    <= 1'b0;
      end else begin
         r_kill      <= w_kill_nxt;
         r_mem_req   <= w_mem_req_nxt;
         r_mem_we    <= w_mem_we_nxt;
         r_mem_be    <= w_mem_be_nxt;
         r_mem_addr  <= w_mem_addr_nxt;
         r_mem_wdata <= w_mem_wdata_nxt;
         r_i_rdata   <= w_i_rdata_nxt;
         r_d_rdata   <= w_d_rdata_nxt;
         r_i_done    <= w_i_done_nxt;
         r_d_done    <= w_d_done_nxt;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      w_state_nxt     = r_state;
      w_kill_nxt      = r_kill;
      w_mem_req_nxt   = r_mem_req;
      w_mem_we_nxt    = r_mem_we;
      w_mem_be_nxt    = r_mem_be;
      w_mem_addr_nxt  = r_mem_addr;
      w_mem_wdata_nxt = r_mem_wdata;
      w_i_rdata_nxt   = r_i_rdata;
      w_d_rdata_nxt   = r_d_rdata;
      w_i_done_nxt    = 1'b0;
      w_d_done_nxt    = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_kill_nxt = 1'b0;
            if (w_pick_d) begin
               w_mem_req_nxt   = 1'b1;
               w_mem_we_nxt    = bus.d_we_i;
               w_mem_be_nxt    = bus.d_be_i;
               w_mem_addr_nxt  = bus.d_addr_i;
               w_mem_wdata_nxt = bus.d_wdata_i;
               w_state_nxt     = ST_D_REQ;
            end else if (w_i_elig) begin
               w_mem_req_nxt   = 1'b1;
               w_mem_we_nxt    = 1'b0;
               w_mem_be_nxt    = '1;
               w_mem_addr_nxt  = bus.i_addr_i;
               w_mem_wdata_nxt = '0;
               w_state_nxt     = ST_I_REQ;
            end
         end
         ST_I_REQ: begin
            if (bus.i_flush_i) w_kill_nxt = 1'b1;
            if (bus.mem_gnt_i) begin
               w_mem_req_nxt = 1'b0;
               w_state_nxt   = ST_I_WAIT;
            end
         end
         ST_I_WAIT: begin
            if (bus.i_flush_i) w_kill_nxt = 1'b1;
            if (bus.mem_rvalid_i) begin
               // A flush arriving together with the response kills it too.
               if (!(r_kill || bus.i_flush_i)) begin
                  w_i_rdata_nxt = bus.mem_rdata_i;
                  w_i_done_nxt  = 1'b1;
               end
               w_kill_nxt  = 1'b0;
               w_state_nxt = ST_IDLE;
            end
         end
         ST_D_REQ: begin
            if (bus.mem_gnt_i) begin
               w_mem_req_nxt = 1'b0;
               w_state_nxt   = ST_D_WAIT;
            end
         end
         ST_D_WAIT: begin
            if (bus.mem_rvalid_i) begin
               w_d_rdata_nxt = bus.mem_rdata_i;
               w_d_done_nxt  = 1'b1;
               w_state_nxt   = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign bus.mem_req_o   = r_mem_req;
   assign bus.mem_we_o    = r_mem_we;
   assign bus.mem_be_o    = r_mem_be;
   assign bus.mem_addr_o  = r_mem_addr;
   assign bus.mem_wdata_o = r_mem_wdata;
   assign bus.i_rdata_o   = r_i_rdata;
   assign bus.i_done_o    = r_i_done;
   assign bus.d_rdata_o   = r_d_rdata;
   assign bus.d_done_o    = r_d_done;
   assign bus.f_stall_o   = w_i_elig;
   assign bus.m_stall_o   = w_d_elig;
   assign o_dbg_state     = r_state;
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one single-port memory bus between the fetch-stage instruction port (I) and the memory-stage data port (D) of the 5-stage core.
- Each request runs through a grant/response handshake with the memory. The block returns read data with a one-cycle done pulse per port.
- Drives per-port stall requests into hazard control.
- Discards fetch responses killed by a branch-mispredict flush.

Parameters:
XLEN, 32, data width
AW, 32, address width (matches PC_WIDTH)

Ports:
clk_i  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
i_req_i  in  1  fetch request; held with i_addr_i stable until i_done_o
i_addr_i  in  AW  fetch address
i_flush_i  in  1  kill in-flight/pending fetch (mispredict redirect)
i_rdata_o  out  XLEN  fetched word, valid when i_done_o
i_done_o  out  1  one-cycle fetch completion pulse
d_req_i  in  1  data request; held with d_* stable until d_done_o
d_we_i  in  1  1=store, 0=load
d_be_i  in  XLEN/8  byte enables
d_addr_i  in  AW  data address
d_wdata_i  in  XLEN  store data
d_rdata_o  out  XLEN  load data, valid when d_done_o
d_done_o  out  1  one-cycle data completion pulse
f_stall_o  out  1  i_req_i & ~i_done_o & ~i_flush_i
m_stall_o  out  1  d_req_i & ~d_done_o
mem_req_o  out  1  bus request
mem_we_o  out  1  bus write
mem_be_o  out  XLEN/8  bus byte enables (all-ones for fetch)
mem_addr_o  out  AW  bus address
mem_wdata_o  out  XLEN  bus write data
mem_gnt_i  in  1  memory accepted request this cycle
mem_rvalid_i  in  1  response/write-ack this cycle
mem_rdata_i  in  XLEN  response data

Behaviour:
- Reset (rst=0, async):
  - FSM goes to IDLE.
  - All outputs are 0, except f_stall_o and m_stall_o, which stay combinational.
  - kill flag = 0; last_grant = I.
- FSM states: IDLE, I_REQ, I_WAIT, D_REQ, D_WAIT.
- IDLE:
  - Eligible requests: i_req_i & ~i_done_o & ~i_flush_i, and d_req_i & ~d_done_o. The done qualifier blocks re-issue of a request that completed this cycle.
  - If both are eligible, D wins (older instruction).
  - The winner's address, data, we and be are registered onto the mem_* outputs. mem_req_o=1 next cycle, and the FSM moves to X_REQ.
  - For fetch: mem_we_o=0, mem_be_o=all-ones, mem_wdata_o=0.
- X_REQ:
  - mem_req_o and all mem_* outputs are held stable until mem_gnt_i=1.
  - On gnt: mem_req_o=0 next cycle; go to X_WAIT.
- X_WAIT:
  - On mem_rvalid_i: mem_rdata_i is registered into the port's rdata_o, and done_o=1 the next cycle for exactly one cycle. Go to IDLE.
  - Stores also wait for rvalid (write ack); d_rdata_o is then don't-care.
- Minimum latency with zero-wait memory (gnt same cycle, rvalid next cycle): request seen in cycle 0 → done in cycle 3.
- Flush:
  - i_flush_i in IDLE, or while the I request is not yet issued: fetch is not arbitrated.
  - i_flush_i in I_REQ or I_WAIT: kill flag set. The bus handshake still completes (mem_req_o is never withdrawn before gnt).
  - Response with kill=1: no i_done_o, i_rdata_o unchanged, kill cleared on return to IDLE.
  - Flush has no effect on the D port.
- Request/response data: rdata_o holds its last value between done pulses.
- rvalid handling: mem_rvalid_i in IDLE, X_REQ, or the wrong port's WAIT state is ignored.
- mem_gnt_i outside X_REQ is ignored.
- Reset mid-transaction: the FSM abandons the transaction. Any later stray rvalid is ignored per the rule above.
- Bus ownership: no new arbitration while in a REQ/WAIT state; one outstanding transaction maximum.

Optional Feature:
MEM_ARB_RR_EN
- Defined: round-robin.
  - last_grant is updated on each IDLE grant.
  - If both ports are eligible in IDLE, the port not in last_grant wins.
  - A single eligible port always wins.
- Undefined: fixed D-over-I priority; last_grant is not implemented.

Test Plan:
- Fetch only, addr 0x1000, gnt same cycle, rvalid next cycle with 0x00000013 → mem_addr_o=0x1000, mem_be_o=0xF, i_done_o pulses in cycle 3 with i_rdata_o=0x00000013; f_stall_o=1 in cycles 0–2.
- Both request in same IDLE cycle (I 0x2000, D load 0x8000) → D issued first; I issued in the IDLE after d_done_o. With MEM_ARB_RR_EN and last_grant=D, I is issued first.
- Store d_addr=0x8004, be=0x3, wdata=0xDEADBEEF, gnt delayed 3 cycles → mem_* outputs stable for all 4 REQ cycles, mem_we_o=1; d_done_o one pulse after ack.
- i_flush_i during I_WAIT, then rvalid with 0xFFFFFFFF → no i_done_o, i_rdata_o keeps its prior value; next fetch to 0x3000 completes normally.
- rst low during D_WAIT, then rvalid after release → all outputs 0, stray rvalid ignored, no d_done_o; next request runs normally.
